// File: rtl/mem_bus_responder.sv
// mem_bus_responder: main-memory responder on the shared system bus.
// Acknowledges transfers selected by DEST_IN and streams 32-bit beats
// between the bus (D) and a single-port synchronous RAM (MEM_*).
// Ports: BUS_CLK/RST (async active-low), D inout bus data, A/SIZE/RW
// request sampled with DEST_IN, ACK_OUT/BUSY/DONE/ERR status, MEM_EN/
// MEM_WR/MEM_A/MEM_WDATA/MEM_RDATA RAM port (word address).
// Optional build macro MEM_RESP_SIZE_CHECK_EN rejects SIZE=0 or
// SIZE not a multiple of 4 with an ERR pulse instead of an ACK_OUT.
module mem_bus_responder #(
   parameter int TURNAROUND = 1
) (
   input  logic        BUS_CLK,
   input  logic        RST,
   inout  wire  [31:0] D,
   input  logic [15:0] A,
   input  logic [11:0] SIZE,
   input  logic        RW,
   input  logic        DEST_IN,
   output logic        ACK_OUT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic        MEM_EN,
   output logic        MEM_WR,
   output logic [13:0] MEM_A,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA
);

   typedef enum logic [2:0] {
      IDLE,
      ACK,
      RD,
      WR,
      TURN
   } state_t;

   localparam logic [1:0] TLAST = 2'(TURNAROUND - 1);

   state_t     state;
   logic [9:0] cnt;
   logic       rw_q;
   logic [1:0] tcnt;
   logic       reject;
   logic       unused_lsb;

`ifdef MEM_RESP_SIZE_CHECK_EN
   assign reject = (SIZE == 12'd0) || (SIZE[1:0] != 2'd0);
`else
   assign reject = 1'b0;
`endif

   // byte-offset bits carry no meaning on a word-wide RAM
   assign unused_lsb = ^{A[1:0], SIZE[1:0]};

   assign D         = (state == RD) ? MEM_RDATA : 32'bz;
   assign MEM_WDATA = (state == WR) ? D : 32'd0;

   // MEM_A doubles as the address register. On reads it runs one word
   // ahead of the beat on D, since RAM data arrives a cycle late.
   always_ff @(posedge BUS_CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         cnt     <= '0;
         rw_q    <= 1'b0;
         tcnt    <= '0;
         ACK_OUT <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         MEM_EN  <= 1'b0;
         MEM_WR  <= 1'b0;
         MEM_A   <= '0;
      end else begin
         ACK_OUT <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (DEST_IN) begin
                  MEM_A <= A[15:2];
                  cnt   <= SIZE[11:2];
                  rw_q  <= RW;
                  BUSY  <= 1'b1;
                  if (reject) begin
                     state <= TURN;
                     tcnt  <= TLAST;
                     ERR   <= 1'b1;
                  end else begin
                     state   <= ACK;
                     ACK_OUT <= 1'b1;
                     MEM_WR  <= 1'b0;
                     // prefetch beat 0 during the ACK cycle
                     MEM_EN  <= !RW && (SIZE[11:2] != 10'd0);
                  end
               end
            end
            ACK: begin
               if (cnt == 10'd0) begin
                  state  <= TURN;
                  tcnt   <= TLAST;
                  MEM_EN <= 1'b0;
               end else if (rw_q) begin
                  state  <= WR;
                  MEM_EN <= 1'b1;
                  MEM_WR <= 1'b1;
               end else begin
                  state  <= RD;
                  MEM_EN <= cnt > 10'd1;
                  if (cnt > 10'd1)
                     MEM_A <= MEM_A + 14'd1;
               end
            end
            RD: begin
               cnt <= cnt - 10'd1;
               if (cnt == 10'd1) begin
                  state  <= TURN;
                  tcnt   <= TLAST;
                  DONE   <= 1'b1;
                  MEM_EN <= 1'b0;
               end else begin
                  MEM_EN <= cnt > 10'd2;
                  if (cnt > 10'd2)
                     MEM_A <= MEM_A + 14'd1;
               end
            end
            WR: begin
               cnt <= cnt - 10'd1;
               if (cnt == 10'd1) begin
                  state  <= TURN;
                  tcnt   <= TLAST;
                  DONE   <= 1'b1;
                  MEM_EN <= 1'b0;
                  MEM_WR <= 1'b0;
               end else begin
                  MEM_A <= MEM_A + 14'd1;
               end
            end
            TURN: begin
               if (tcnt == 2'd0) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  tcnt <= tcnt - 2'd1;
               end
            end
            default: begin
               state  <= IDLE;
               BUSY   <= 1'b0;
               MEM_EN <= 1'b0;
               MEM_WR <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: scoreboard bench for mem_bus_responder.
// Behavioural RAM on the MEM_* port; expected read beats are queued.
module tb_mem_bus_responder;

   localparam int T = 1;

   logic        BUS_CLK;
   logic        RST;
   wire  [31:0] D;
   logic [15:0] A;
   logic [11:0] SIZE;
   logic        RW;
   logic        DEST_IN;
   logic        ACK_OUT;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic        MEM_EN;
   logic        MEM_WR;
   logic [13:0] MEM_A;
   logic [31:0] MEM_WDATA;
   logic [31:0] MEM_RDATA;

   // master side of D: drives data on writes, zero otherwise, so a
   // DUT that drives outside RD shows up as a nonzero value
   logic [31:0] d_drv;
   logic        d_oe;
   assign D = d_oe ? d_drv : 32'bz;

   logic        pl_en;
   logic [13:0] pl_a;
   logic [31:0] pl_d;
   logic [31:0] ram    [16384];
   logic [31:0] shadow [16384];
   logic [31:0] exp_q  [$];

   int n_chk;
   int n_err;

   mem_bus_responder #(.TURNAROUND(T)) dut (
      .BUS_CLK   (BUS_CLK),
      .RST       (RST),
      .D         (D),
      .A         (A),
      .SIZE      (SIZE),
      .RW        (RW),
      .DEST_IN   (DEST_IN),
      .ACK_OUT   (ACK_OUT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR),
      .MEM_EN    (MEM_EN),
      .MEM_WR    (MEM_WR),
      .MEM_A     (MEM_A),
      .MEM_WDATA (MEM_WDATA),
      .MEM_RDATA (MEM_RDATA)
   );

   initial begin
      BUS_CLK = 1'b0;
      forever #5 BUS_CLK = ~BUS_CLK;
   end

   always @(posedge BUS_CLK) begin
      if (pl_en)
         ram[pl_a] <= pl_d;
      else if (MEM_EN) begin
         if (MEM_WR)
            ram[MEM_A] <= MEM_WDATA;
         else
            MEM_RDATA <= ram[MEM_A];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic check1(input string tag,
                         input logic act,
                         input logic exp);
      check(tag, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic step();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic preload(input logic [13:0] w,
                          input logic [31:0] v);
      pl_en = 1'b1;
      pl_a  = w;
      pl_d  = v;
      shadow[w] = v;
      step();
      pl_en = 1'b0;
   endtask

   task automatic turn_idle();
      for (int t = 1; t < T; t++) begin
         step();
         check1("turn_busy", BUSY, 1'b1);
      end
      step();
      check1("idle_busy", BUSY, 1'b0);
   endtask

   task automatic run_rd(input logic [15:0] a,
                         input logic [11:0] sz,
                         input bit poke);
      int n;
      logic [13:0] w;
      n = int'(sz[11:2]);
      w = a[15:2];
      for (int k = 0; k < n; k++)
         exp_q.push_back(shadow[14'(w + 14'(k))]);
      A = a; SIZE = sz; RW = 1'b0; DEST_IN = 1'b1;
      step();
      DEST_IN = 1'b0; A = 16'hDEAD; SIZE = 12'hFFF; RW = 1'b1;
      d_oe = 1'b0;
      check1("rd_ack", ACK_OUT, 1'b1);
      check1("rd_en0", MEM_EN, 1'b1);
      check1("rd_wr0", MEM_WR, 1'b0);
      check("rd_a0", 32'(MEM_A), 32'(w));
      for (int k = 0; k < n; k++) begin
         step();
         check("rd_data", D, exp_q.pop_front());
         check1("rd_ackoff", ACK_OUT, 1'b0);
         check1("rd_busy", BUSY, 1'b1);
         if (k < n - 1) begin
            check1("rd_en", MEM_EN, 1'b1);
            check("rd_a", 32'(MEM_A), 32'(14'(w + 14'(k + 1))));
         end else begin
            check1("rd_enoff", MEM_EN, 1'b0);
         end
         if (poke && k == 0) begin
            DEST_IN = 1'b1; A = 16'h1234; SIZE = 12'h040; RW = 1'b1;
         end else begin
            DEST_IN = 1'b0;
         end
      end
      step();
      d_oe = 1'b1;
      #1;
      check1("rd_done", DONE, 1'b1);
      check("rd_float", D, 32'd0);
      if (poke) begin
         DEST_IN = 1'b1; A = 16'h1234; SIZE = 12'h040; RW = 1'b1;
      end
      turn_idle();
      check1("rd_done1", DONE, 1'b0);
      check1("rd_noack", ACK_OUT, 1'b0);
      DEST_IN = 1'b0;
   endtask

   task automatic run_wr(input logic [15:0] a,
                         input logic [11:0] sz,
                         input logic [31:0] seed);
      int n;
      logic [13:0] w;
      logic [31:0] v;
      n = int'(sz[11:2]);
      w = a[15:2];
      A = a; SIZE = sz; RW = 1'b1; DEST_IN = 1'b1;
      step();
      DEST_IN = 1'b0; RW = 1'b0; A = 16'h0000;
      check1("wr_ack", ACK_OUT, 1'b1);
      check1("wr_en0", MEM_EN, 1'b0);
      for (int k = 0; k < n; k++) begin
         step();
         v = seed * 32'(k + 1);
         d_drv = v;
         #1;
         shadow[14'(w + 14'(k))] = v;
         check1("wr_en", MEM_EN, 1'b1);
         check1("wr_wr", MEM_WR, 1'b1);
         check("wr_a", 32'(MEM_A), 32'(14'(w + 14'(k))));
         check("wr_data", MEM_WDATA, v);
      end
      step();
      d_drv = 32'd0;
      #1;
      check1("wr_done", DONE, 1'b1);
      check1("wr_enoff", MEM_EN, 1'b0);
      turn_idle();
      for (int k = 0; k < n; k++)
         check("wr_ram", ram[14'(w + 14'(k))], shadow[14'(w + 14'(k))]);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      RST = 1'b0; DEST_IN = 1'b0; A = '0; SIZE = '0; RW = 1'b0;
      d_oe = 1'b1; d_drv = 32'hFFFF0000;
      pl_en = 1'b0; pl_a = '0; pl_d = '0;
      for (int i = 0; i < 16384; i++) shadow[i] = 32'd0;
      repeat (3) step();
      check1("rst_ack", ACK_OUT, 1'b0);
      check1("rst_busy", BUSY, 1'b0);
      check1("rst_done", DONE, 1'b0);
      check1("rst_err", ERR, 1'b0);
      check1("rst_en", MEM_EN, 1'b0);
      check1("rst_wr", MEM_WR, 1'b0);
      check("rst_a", 32'(MEM_A), 32'd0);
      check("rst_wdata", MEM_WDATA, 32'd0);
      d_drv = 32'd0;
      #1;
      check("rst_float", D, 32'd0);
      RST = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         preload(14'(14'h0100 + 14'(i)), 32'hA0 + 32'(i));
         preload(14'(14'h0200 + 14'(i)), 32'hDEAD0000 + 32'(i));
      end
      preload(14'h3FFE, 32'hC0FFEE00);
      preload(14'h3FFF, 32'hC0FFEE01);
      preload(14'h0000, 32'hC0FFEE02);
      preload(14'h0001, 32'hC0FFEE03);
      preload(14'h0050, 32'h5A5A0050);

      run_rd(16'h0400, 12'h010, 1'b0);
      run_wr(16'h0800, 12'h010, 32'h11111111);
      run_rd(16'h0800, 12'h010, 1'b0);
      run_rd(16'hFFF8, 12'h010, 1'b0);
      run_rd(16'h0402, 12'h00B, 1'b1);
      run_wr(16'hFFFC, 12'h008, 32'h01020304);
      run_rd(16'h0140, 12'h004, 1'b0);

      A = 16'h0400; SIZE = 12'h010; RW = 1'b0; DEST_IN = 1'b1;
      step();
      DEST_IN = 1'b0; d_oe = 1'b0;
      step();
      check("mr_b0", D, 32'hA0);
      step();
      check("mr_b1", D, 32'hA1);
      step();
      check("mr_b2", D, 32'hA2);
      #2;
      RST = 1'b0; d_oe = 1'b1;
      #1;
      check1("mr_busy", BUSY, 1'b0);
      check("mr_float", D, 32'd0);
      check1("mr_en", MEM_EN, 1'b0);
      check1("mr_ack", ACK_OUT, 1'b0);
      step();
      RST = 1'b1;
      step();
      run_rd(16'h0404, 12'h00C, 1'b0);

`ifdef MEM_RESP_SIZE_CHECK_EN
      A = 16'h0400; SIZE = 12'h006; RW = 1'b0; DEST_IN = 1'b1;
      step();
      DEST_IN = 1'b0;
      check1("sc_noack", ACK_OUT, 1'b0);
      check1("sc_err", ERR, 1'b1);
      check1("sc_en", MEM_EN, 1'b0);
      check1("sc_busy", BUSY, 1'b1);
      for (int t = 1; t < T; t++) step();
      step();
      check1("sc_err1", ERR, 1'b0);
      check1("sc_idle", BUSY, 1'b0);
`else
      run_rd(16'h0400, 12'h006, 1'b0);
      A = 16'h0400; SIZE = 12'h002; RW = 1'b0; DEST_IN = 1'b1;
      step();
      DEST_IN = 1'b0;
      check1("z_ack", ACK_OUT, 1'b1);
      check1("z_en", MEM_EN, 1'b0);
      check1("z_err", ERR, 1'b0);
      step();
      check1("z_nodone", DONE, 1'b0);
      check1("z_busy", BUSY, 1'b1);
      check1("z_en1", MEM_EN, 1'b0);
      turn_idle();
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
